// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared state encoding and default constants for the fetch block.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [31:0] c_default_reset_pc  = 32'h0000_0000;
  localparam logic [31:0] c_default_halt_word = 32'h0010_0073;

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Program-load write pointer, accept handshake and overflow detect.
// Revision : 1.0
// ============================================================================
module imem_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_load_valid,
  input  logic [31:0]       i_load_data,
  input  logic              i_load_last,
  output logic              o_load_ready,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata,
  output logic              o_load_done,
  output logic              o_load_overflow
);

  logic [ADDR_W-1:0] r_load_ptr;
  logic              w_accept;
  logic              w_ptr_full;

  // Ready is forced low for the whole time reset is held, not just after the edge.
  assign o_load_ready    = i_en & rst_n;
  assign w_accept        = i_load_valid & o_load_ready;
  assign w_ptr_full      = &r_load_ptr;

  assign o_we            = w_accept;
  assign o_addr          = r_load_ptr;
  assign o_wdata         = i_load_data;
  assign o_load_done     = w_accept & i_load_last;
  assign o_load_overflow = w_accept & ~i_load_last & w_ptr_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_ptr <= '0;
    end else if (w_accept) begin
      r_load_ptr <= r_load_ptr + ADDR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Loads the instruction memory, then fetches one word per cycle.
// Revision : 1.0
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] RESET_PC  = c_default_reset_pc,
  parameter logic [31:0] HALT_WORD = c_default_halt_word
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  output logic              halted,
  output logic              fault
);

  state_t            r_state;
  logic [31:0]       r_pc;
  logic [31:0]       r_instr;
  logic [31:0]       r_instr_pc;
  logic              r_instr_valid;
  logic              r_halted;
  logic              r_fault;

  logic              w_load_en;
  logic              w_ld_we;
  logic [ADDR_W-1:0] w_ld_addr;
  logic              w_load_done;
  logic              w_load_overflow;
  logic              w_pc_out_of_range;

  assign w_load_en = (r_state == ST_LOAD);

  imem_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_en            (w_load_en),
    .i_load_valid    (load_valid),
    .i_load_data     (load_data),
    .i_load_last     (load_last),
    .o_load_ready    (load_ready),
    .o_we            (w_ld_we),
    .o_addr          (w_ld_addr),
    .o_wdata         (imem_wdata),
    .o_load_done     (w_load_done),
    .o_load_overflow (w_load_overflow)
  );

  assign imem_we           = w_ld_we;
  assign imem_addr         = w_load_en ? w_ld_addr : r_pc[ADDR_W+1:2];
  assign w_pc_out_of_range = (r_pc[31:ADDR_W+2] != '0);

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fault       = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_LOAD;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_instr_valid <= 1'b0;
          if (w_load_done) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
          end else if (w_load_overflow) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end
        end
        ST_RUN: begin
          // Redirect outranks stall so a taken branch always flushes the slot.
          if (redirect_valid) begin
            r_instr_valid <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end else begin
              r_pc <= redirect_pc;
            end
          end else if (w_pc_out_of_range) begin
            r_instr_valid <= 1'b0;
            r_state       <= ST_FAULT;
            r_fault       <= 1'b1;
          end else if (!stall) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            if (imem_rdata == HALT_WORD) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end else begin
              r_pc <= r_pc + 32'd4;
            end
          end
        end
        ST_HALT: begin
          if (!stall) begin
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed vector table plus hand sequences for fetch_ctrl.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] HW  = 32'h0010_0073;
  localparam int          NV  = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic        fault;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        lv;
    logic [31:0] ld;
    logic        ll;
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        e_rdy;
    logic        e_we;
    logic        chk_addr;
    logic [9:0]  e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_halt;
    logic        e_fault;
  } vec_t;

  vec_t vecs [NV];

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_wdata     (imem_wdata),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // 1024 x 32 memory: synchronous write, asynchronous read.
  always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;
  assign imem_rdata = mem[imem_addr];

  function automatic vec_t mk(logic lv, logic [31:0] ld, logic ll, logic st, logic rv,
                              logic [31:0] rpc, logic rdy, logic we, logic ca, logic [9:0] ad,
                              logic iv, logic [31:0] ins, logic [31:0] ipc, logic h, logic f);
    vec_t v;
    v.lv = lv; v.ld = ld; v.ll = ll; v.st = st; v.rv = rv; v.rpc = rpc;
    v.e_rdy = rdy; v.e_we = we; v.chk_addr = ca; v.e_addr = ad; v.e_iv = iv;
    v.e_instr = ins; v.e_ipc = ipc; v.e_halt = h; v.e_fault = f;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic load_words(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = (i == n - 1) ? HW : (base | (32'(i) << 7));
      load_last  = (i == n - 1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1, NOP, 0, 0, 0, 0,    1, 1, 1, 10'd0, 0, 0,   0,     0, 0);
    vecs[1]  = mk(1, NOP, 0, 1, 0, 0,    1, 1, 1, 10'd1, 0, 0,   0,     0, 0);
    vecs[2]  = mk(1, NOP, 0, 0, 1, 6,    1, 1, 1, 10'd2, 0, 0,   0,     0, 0);
    vecs[3]  = mk(1, HW,  1, 0, 0, 0,    1, 1, 1, 10'd3, 0, 0,   0,     0, 0);
    vecs[4]  = mk(0, 0,   0, 0, 0, 0,    0, 0, 1, 10'd0, 0, 0,   0,     0, 0);
    vecs[5]  = mk(0, 0,   0, 0, 0, 0,    0, 0, 1, 10'd1, 1, NOP, 0,     0, 0);
    vecs[6]  = mk(0, 0,   0, 0, 0, 0,    0, 0, 1, 10'd2, 1, NOP, 4,     0, 0);
    vecs[7]  = mk(0, 0,   0, 0, 0, 0,    0, 0, 1, 10'd3, 1, NOP, 8,     0, 0);
    vecs[8]  = mk(0, 0,   0, 1, 0, 0,    0, 0, 0, 10'd0, 1, HW,  32'hC, 1, 0);
    vecs[9]  = mk(0, 0,   0, 0, 0, 0,    0, 0, 0, 10'd0, 1, HW,  32'hC, 1, 0);
    vecs[10] = mk(1, NOP, 0, 0, 1, 6,    0, 0, 0, 10'd0, 0, HW,  32'hC, 1, 0);
    vecs[11] = mk(0, 0,   0, 0, 0, 0,    0, 0, 0, 10'd0, 0, HW,  32'hC, 1, 0);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_load_ready", 32'(load_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    rst_n = 1'b1;

    // Table: 4-word program ending in HALT_WORD, then halt behaviour.
    for (int i = 0; i < NV; i++) begin
      load_valid = vecs[i].lv; load_data = vecs[i].ld; load_last = vecs[i].ll;
      stall = vecs[i].st; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_load_ready", i), 32'(load_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_imem_we", i), 32'(imem_we), 32'(vecs[i].e_we));
      if (vecs[i].chk_addr) chk($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_iv));
      chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
      chk($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].e_ipc);
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_halt));
      chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].e_fault));
      step();
    end

    // Stall, stall+redirect, misaligned redirect.
    do_reset();
    load_words(8, 32'h0000_0013);
    begin
      bit found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
        if (instr_valid && instr_pc == 32'd4) found = 1;
        else step();
      end
      chk("wait_instr_pc4", 32'(found), 1);
    end
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall%0d_iv", c), 32'(instr_valid), 1);
      chk($sformatf("stall%0d_pc", c), instr_pc, 32'd4);
      chk($sformatf("stall%0d_instr", c), instr, 32'h0000_0093);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", instr_pc, 32'd8);
    chk("unstall_instr", instr, 32'h0000_0113);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    chk("redir_flush_iv", 32'(instr_valid), 0);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    chk("redir_target_iv", 32'(instr_valid), 1);
    chk("redir_target_pc", instr_pc, 32'h10);
    chk("redir_target_instr", instr, 32'h0000_0213);
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    step();
    chk("misalign_fault", 32'(fault), 1);
    chk("misalign_iv", 32'(instr_valid), 0);
    redirect_pc = 32'h0; load_valid = 1'b1; load_data = NOP;
    #1;
    chk("fault_load_ready", 32'(load_ready), 0);
    chk("fault_imem_we", 32'(imem_we), 0);
    step();
    chk("fault_sticky", 32'(fault), 1);
    chk("fault_iv", 32'(instr_valid), 0);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("fault_async_rst", 32'(fault), 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_fault_rst_ready", 32'(load_ready), 1);

    // Redirect just past the top of memory.
    do_reset();
    load_words(2, NOP);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    step();
    redirect_valid = 1'b0;
    chk("oor_fault_pending", 32'(fault), 0);
    chk("oor_iv0", 32'(instr_valid), 0);
    step();
    chk("oor_fault", 32'(fault), 1);
    chk("oor_iv1", 32'(instr_valid), 0);

    // Overflow: 1024 words without load_last.
    do_reset();
    begin
      int bad = 0;
      for (int i = 0; i < 1024; i++) begin
        load_valid = 1'b1; load_data = 32'hA5A5_0000 | 32'(i); load_last = 1'b0;
        #1;
        if (!imem_we || imem_addr != 10'(i)) bad++;
        step();
      end
      chk("ovf_stream_we_addr_errs", 32'(bad), 0);
    end
    #1;
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_halted", 32'(halted), 0);
    chk("ovf_we_blocked", 32'(imem_we), 0);
    chk("ovf_mem0", mem[0], 32'hA5A5_0000);
    chk("ovf_mem1023", mem[1023], 32'hA5A5_03FF);
    load_valid = 1'b0;

    // Reset mid-load, then reset mid-run.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      load_valid = 1'b1; load_data = NOP; load_last = 1'b0;
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("midload_rst_ready", 32'(load_ready), 0);
    chk("midload_rst_we", 32'(imem_we), 0);
    chk("midload_rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    load_last = 1'b1;
    #1;
    chk("midload_ptr0", 32'(imem_addr), 0);
    step();
    load_valid = 1'b0; load_last = 1'b0;
    step();
    chk("run_after_reload_iv", 32'(instr_valid), 1);
    chk("run_after_reload_instr", instr, NOP);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_iv", 32'(instr_valid), 0);
    chk("midrun_rst_instr", instr, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("midrun_rst_to_load", 32'(load_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
